// File: rtl/bus_arbiter_pkg.sv
// Shared constants and state encoding for the CPU bus arbiter.
package bus_arbiter_pkg;
   localparam int IO_ADDR_WIDTH = 32;
   localparam int IO_DATA_WIDTH = 32;
   localparam int ARB_TIMEOUT   = 16;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_BUSY = 2'd1,
      ARB_ACK  = 2'd2
   } arb_state_t;
endpackage

// File: rtl/bus_arbiter_rr2.sv
// Two-way round-robin picker: a lone requester wins outright, on a tie the
// port that did not win last time gets the grant.
module arb_rr2 (
   input  logic [1:0] req,
   input  logic       last_grant,   // index of the port granted last
   output logic [1:0] grant
);
   // one-hot grant from request pair and last winner
   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_grant ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end
endmodule

// File: rtl/bus_arbiter.sv
// Shares the data/IO bus between the load/store port (0) and the fetch
// port (1). One transaction at a time; aborts with err if ready never comes.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = IO_ADDR_WIDTH,
   parameter int DATA_WIDTH = IO_DATA_WIDTH,
   parameter int TIMEOUT    = ARB_TIMEOUT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] p0_addr,
   input  logic [DATA_WIDTH-1:0] p0_wdata,
   input  logic                  p0_read,
   input  logic                  p0_write,
   output logic [DATA_WIDTH-1:0] p0_rdata,
   output logic                  p0_ack,
   output logic                  p0_err,
   input  logic [ADDR_WIDTH-1:0] p1_addr,
   input  logic [DATA_WIDTH-1:0] p1_wdata,
   input  logic                  p1_read,
   input  logic                  p1_write,
   output logic [DATA_WIDTH-1:0] p1_rdata,
   output logic                  p1_ack,
   output logic                  p1_err,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   inout  wire  [DATA_WIDTH-1:0] bus_data,
   output logic                  bus_read,
   output logic                  bus_write,
   input  logic                  bus_ready,
   output logic                  busy
);
   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   arb_state_t            state, state_nxt;
   logic [1:0]            req, grant;
   logic                  last_grant;
   logic                  owner;      // port that holds the bus
   logic                  op_write;   // latched op of the owner
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [CW-1:0]         cnt;
   logic                  done, tmo, drive;

   assign req  = {p1_read | p1_write, p0_read | p0_write};
   assign done = (state == ARB_BUSY) && bus_ready;
   assign tmo  = (state == ARB_BUSY) && !bus_ready && (cnt == CW'(TIMEOUT - 1));

   arb_rr2 u_rr (
      .req        (req),
      .last_grant (last_grant),
      .grant      (grant)
   );

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= ARB_IDLE;
      else        state <= state_nxt;
   end

   // next-state: grant from IDLE, leave BUSY on ready or timeout, ACK lasts one cycle
   always_comb begin
      state_nxt = state;
      case (state)
         ARB_IDLE: if (grant != 2'b00) state_nxt = ARB_BUSY;
         ARB_BUSY: if (done || tmo)    state_nxt = ARB_ACK;
         ARB_ACK:                      state_nxt = ARB_IDLE;
         default:                      state_nxt = ARB_IDLE;
      endcase
   end

   // outputs: busy from state, bus_data only driven while a write holds the bus
   always_comb begin
      busy  = (state != ARB_IDLE);
      drive = (state == ARB_BUSY) && op_write;
   end

   assign bus_data = drive ? wdata_q : {DATA_WIDTH{1'bz}};

   // latched request, strobes, timeout counter, per-port ack/err/rdata
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_grant <= 1'b1;
         owner      <= 1'b0;
         op_write   <= 1'b0;
         wdata_q    <= '0;
         cnt        <= '0;
         bus_addr   <= '0;
         bus_read   <= 1'b0;
         bus_write  <= 1'b0;
         p0_ack     <= 1'b0;
         p0_err     <= 1'b0;
         p1_ack     <= 1'b0;
         p1_err     <= 1'b0;
         p0_rdata   <= '0;
         p1_rdata   <= '0;
      end else begin
         p0_ack <= 1'b0;
         p0_err <= 1'b0;
         p1_ack <= 1'b0;
         p1_err <= 1'b0;
         case (state)
            ARB_IDLE: if (grant != 2'b00) begin
               owner      <= grant[1];
               last_grant <= grant[1];
               cnt        <= '0;
               bus_addr   <= grant[1] ? p1_addr  : p0_addr;
               wdata_q    <= grant[1] ? p1_wdata : p0_wdata;
               op_write   <= grant[1] ? p1_write : p0_write;
               bus_write  <= grant[1] ? p1_write : p0_write;
               bus_read   <= grant[1] ? !p1_write : !p0_write;
            end
            ARB_BUSY: begin
               if (done || tmo) begin
                  bus_read  <= 1'b0;
                  bus_write <= 1'b0;
                  if (owner) begin
                     p1_ack <= 1'b1;
                     p1_err <= tmo;
                  end else begin
                     p0_ack <= 1'b1;
                     p0_err <= tmo;
                  end
                  if (done && !op_write) begin
                     if (owner) p1_rdata <= bus_data;
                     else       p0_rdata <= bus_data;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level model (winner, latency, data).
module tb_bus_arbiter;
   import bus_arbiter_pkg::*;
   localparam int AW = IO_ADDR_WIDTH;
   localparam int DW = IO_DATA_WIDTH;
   localparam int TO = ARB_TIMEOUT;
   localparam int NEVER = 1000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [AW-1:0] p0_addr = '0, p1_addr = '0;
   logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
   logic p0_read = 0, p0_write = 0, p1_read = 0, p1_write = 0;
   wire  [DW-1:0] p0_rdata, p1_rdata;
   wire  p0_ack, p0_err, p1_ack, p1_err;
   wire  [AW-1:0] bus_addr;
   wire  [DW-1:0] bus_data;
   wire  bus_read, bus_write, busy;
   logic bus_ready = 1'b0;
   logic tb_en = 1'b0;
   logic [DW-1:0] tb_drv = '0;

   assign bus_data = tb_en ? tb_drv : {DW{1'bz}};

   bus_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_read(p0_read), .p0_write(p0_write),
      .p0_rdata(p0_rdata), .p0_ack(p0_ack), .p0_err(p0_err),
      .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_read(p1_read), .p1_write(p1_write),
      .p1_rdata(p1_rdata), .p1_ack(p1_ack), .p1_err(p1_err),
      .bus_addr(bus_addr), .bus_data(bus_data), .bus_read(bus_read),
      .bus_write(bus_write), .bus_ready(bus_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // reference model: port that won last, last data delivered to each port
   bit m_last = 1'b1;
   logic [DW-1:0] m_rdata [2];

   task automatic drop_all();
      p0_read = 0; p0_write = 0; p1_read = 0; p1_write = 0;
      bus_ready = 0; tb_en = 0;
   endtask

   // two reset cycles; checks the cleared outputs and that bus_data is released
   task automatic apply_reset();
      logic [DW-1:0] pat;
      pat = 32'hA5C3_5A3C;
      @(negedge clk);
      rst_n = 0;
      drop_all();
      @(posedge clk); #1;
      checks++;
      if ({bus_read, bus_write, p0_ack, p1_ack, p0_err, p1_err, busy} !== 7'b0) begin
         errors++; $display("FAIL reset_ctl got %b exp 0", {bus_read, bus_write, p0_ack, p1_ack, p0_err, p1_err, busy});
      end
      checks++;
      if (p0_rdata !== '0 || p1_rdata !== '0) begin
         errors++; $display("FAIL reset_rdata got %h/%h exp 0", p0_rdata, p1_rdata);
      end
      @(negedge clk);
      tb_en = 1; tb_drv = pat;
      #1;
      checks++;
      if (bus_data !== pat) begin
         errors++; $display("FAIL reset_bus_data got %h exp %h", bus_data, pat);
      end
      tb_en = 0;
      @(posedge clk); #1;
      checks++;
      if (bus_addr !== '0) begin
         errors++; $display("FAIL reset_addr got %h exp 0", bus_addr);
      end
      @(negedge clk);
      rst_n = 1;
      m_last = 1'b1;
      m_rdata[0] = '0;
      m_rdata[1] = '0;
   endtask

   // one complete transaction; dly = BUSY cycles before ready (NEVER = time out)
   task automatic do_txn(input bit r0, input bit w0, input bit r1, input bit w1,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                         input int dly, input logic [DW-1:0] rv);
      bit q0, q1, win, wr, acked, tmo;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      int strobes, exp_strobes;
      q0 = r0 | w0;
      q1 = r1 | w1;
      win = (q0 && q1) ? !m_last : q1;
      m_last = win;
      wr = win ? w1 : w0;
      ea = win ? a1 : a0;
      ed = win ? d1 : d0;
      @(negedge clk);
      p0_read = r0; p0_write = w0; p0_addr = a0; p0_wdata = d0;
      p1_read = r1; p1_write = w1; p1_addr = a1; p1_wdata = d1;
      @(posedge clk); #1;
      checks++;
      if ({bus_read, bus_write, busy} !== {!wr, wr, 1'b1}) begin
         errors++; $display("FAIL grant_strobe got %b exp %b", {bus_read, bus_write, busy}, {!wr, wr, 1'b1});
      end
      checks++;
      if (bus_addr !== ea) begin
         errors++; $display("FAIL grant_addr got %h exp %h", bus_addr, ea);
      end
      @(negedge clk);
      p0_read = 0; p0_write = 0; p1_read = 0; p1_write = 0;
      strobes = 0; acked = 0; tmo = 0;
      for (int k = 0; k < TO && !acked; k++) begin
         bus_ready = (k == dly);
         tb_en = !wr;
         tb_drv = rv;
         if (bus_read || bus_write) strobes++;
         if (wr) begin
            checks++;
            if (bus_data !== ed) begin
               errors++; $display("FAIL write_data got %h exp %h", bus_data, ed);
            end
         end
         @(posedge clk); #1;
         if (k == dly) acked = 1;
         else if (k == TO - 1) begin acked = 1; tmo = 1; end
         if (!acked) begin
            checks++;
            if ({bus_read, bus_write, p0_ack, p1_ack} !== {!wr, wr, 2'b00}) begin
               errors++; $display("FAIL hold got %b exp %b", {bus_read, bus_write, p0_ack, p1_ack}, {!wr, wr, 2'b00});
            end
            @(negedge clk);
         end
      end
      if (!wr && !tmo) m_rdata[win] = rv;
      exp_strobes = tmo ? TO : dly + 1;
      checks++;
      if ({p1_ack, p0_ack} !== (win ? 2'b10 : 2'b01)) begin
         errors++; $display("FAIL ack got %b exp %b", {p1_ack, p0_ack}, (win ? 2'b10 : 2'b01));
      end
      checks++;
      if ({p1_err, p0_err} !== (tmo ? (win ? 2'b10 : 2'b01) : 2'b00)) begin
         errors++; $display("FAIL err got %b exp tmo=%0d win=%0d", {p1_err, p0_err}, tmo, win);
      end
      checks++;
      if (p0_rdata !== m_rdata[0] || p1_rdata !== m_rdata[1]) begin
         errors++; $display("FAIL rdata got %h/%h exp %h/%h", p0_rdata, p1_rdata, m_rdata[0], m_rdata[1]);
      end
      checks++;
      if ({bus_read, bus_write, busy} !== 3'b001) begin
         errors++; $display("FAIL ack_state got %b exp 001", {bus_read, bus_write, busy});
      end
      checks++;
      if (strobes !== exp_strobes) begin
         errors++; $display("FAIL strobe_len got %0d exp %0d", strobes, exp_strobes);
      end
      @(negedge clk);
      bus_ready = 0; tb_en = 0;
      @(posedge clk); #1;
      checks++;
      if ({p0_ack, p1_ack, p0_err, p1_err, busy} !== 5'b0) begin
         errors++; $display("FAIL after_ack got %b exp 0", {p0_ack, p1_ack, p0_err, p1_err, busy});
      end
   endtask

   task automatic test_reset();
      apply_reset();
      do_txn(1, 0, 0, 0, 32'h44, 0, 0, 0, 1, 32'h7777_0001);
      // start a write and reset while it is on the bus
      @(negedge clk);
      p0_write = 1; p0_addr = 32'h80; p0_wdata = 32'h0BAD_F00D;
      @(posedge clk); #1;
      @(negedge clk);
      p0_write = 0;
      apply_reset();
   endtask

   task automatic test_read();
      do_txn(1, 0, 0, 0, 32'h10, 0, 0, 0, 0, 32'hDEAD_BEEF);
   endtask

   task automatic test_write();
      do_txn(0, 0, 0, 1, 0, 32'h20, 0, 32'h1234_5678, 3, 32'h5555_AAAA);
   endtask

   task automatic test_timeout();
      do_txn(1, 0, 0, 0, 32'h30, 0, 0, 0, NEVER, 32'h9999_9999);
      do_txn(0, 0, 1, 0, 0, 32'h34, 0, 0, 1, 32'h0102_0304);
   endtask

   task automatic test_rw_both();
      do_txn(1, 1, 0, 0, 32'h40, 0, 32'hFEED_FACE, 0, 0, 32'h3333_3333);
   endtask

   task automatic test_ready_idle();
      @(negedge clk);
      bus_ready = 1;
      repeat (3) begin
         @(posedge clk); #1;
         checks++;
         if ({busy, bus_read, bus_write, p0_ack, p1_ack} !== 5'b0) begin
            errors++; $display("FAIL ready_idle got %b exp 0", {busy, bus_read, bus_write, p0_ack, p1_ack});
         end
      end
      @(negedge clk);
      bus_ready = 0;
   endtask

   // both ports request continuously from reset with a target that is always ready
   task automatic test_back_to_back();
      int phase, gidx;
      bit own;
      logic [1:0] exp_ack;
      apply_reset();
      p0_read = 1; p0_addr = 32'h100;
      p1_read = 1; p1_addr = 32'h200;
      bus_ready = 1; tb_en = 1; tb_drv = 32'hCAFE_0000;
      for (int t = 1; t <= 12; t++) begin
         @(posedge clk); #1;
         phase = (t - 1) % 3;
         gidx = (t - 1) / 3;
         own = gidx[0];
         exp_ack = (phase == 1) ? (own ? 2'b10 : 2'b01) : 2'b00;
         checks++;
         if ({p1_ack, p0_ack} !== exp_ack) begin
            errors++; $display("FAIL b2b_ack t=%0d got %b exp %b", t, {p1_ack, p0_ack}, exp_ack);
         end
         checks++;
         if (bus_read !== (phase == 0)) begin
            errors++; $display("FAIL b2b_strobe t=%0d got %b exp %b", t, bus_read, (phase == 0));
         end
         if (phase == 0) begin
            checks++;
            if (bus_addr !== (own ? 32'h200 : 32'h100)) begin
               errors++; $display("FAIL b2b_addr t=%0d got %h exp %h", t, bus_addr, (own ? 32'h200 : 32'h100));
            end
         end
      end
      @(negedge clk);
      drop_all();
      m_last = 1'b1;
      m_rdata[0] = 32'hCAFE_0000;
      m_rdata[1] = 32'hCAFE_0000;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || p0_rdata !== m_rdata[0] || p1_rdata !== m_rdata[1]) begin
         errors++; $display("FAIL b2b_end got busy=%b %h/%h exp 0 %h", busy, p0_rdata, p1_rdata, m_rdata[0]);
      end
   endtask

   task automatic test_random();
      bit r0, w0, r1, w1;
      int dly;
      for (int n = 0; n < 40; n++) begin
         r0 = $urandom_range(0, 1); w0 = $urandom_range(0, 1);
         r1 = $urandom_range(0, 1); w1 = $urandom_range(0, 1);
         if (!(r0 | w0 | r1 | w1)) r0 = 1;
         dly = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, 5);
         do_txn(r0, w0, r1, w1, $urandom, $urandom, $urandom, $urandom, dly, $urandom);
      end
   endtask

   initial begin
      m_rdata[0] = '0;
      m_rdata[1] = '0;
      test_reset();
      test_read();
      test_write();
      test_timeout();
      test_rw_both();
      test_ready_idle();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
